spwtcr_tx_sync: RTL

- Transmit-direction clock-domain crossing for the SpaceWire codec. Carries requests from CLK_SYS into the transmit clock domain (CLOCK).
- Channels: data characters, time-codes, FCT requests and link-control levels.
- Sys-side requests use a toggle/ack protocol. This block synchronises them, captures the held payload, and presents valid/pulse signals to the TX encoder. Ack toggles return to the sys side.
- Sits between the sys-side host interface/FIFO and SpwTCR_TX.

---
 rtl/spwtcr_tx_sync_pkg.sv | 18 +
 rtl/spwtcr_tgl_sync.sv | 42 ++++
 rtl/spwtcr_tx_sync.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spwtcr_tx_sync_pkg.sv
// ----------------------------------------------------------------------------
// spwtcr_tx_sync_pkg
// Shared definitions for the SpaceWire transmit-direction clock-domain
// crossing: data-path FSM states, default parameter values and the width of
// a transmitted character ({EOP/EEP flag, byte}).
// ----------------------------------------------------------------------------
package spwtcr_tx_sync_pkg;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FCT_CNT_W   = 3;
   localparam int CHAR_W          = 9;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } dataState_t;

endpackage

// File: rtl/spwtcr_tgl_sync.sv
// ----------------------------------------------------------------------------
// spwtcr_tgl_sync
// N-stage synchroniser with a history flop for toggle-edge detection.
// A change on tglIn appears on edgeOut for one cycle, STAGES+1 CLOCK edges
// later as seen by a downstream register. Level users ignore edgeOut.
// Ports:
//   CLOCK   in   destination clock
//   RESETn  in   asynchronous active-low reset
//   tglIn   in   asynchronous toggle or level input
//   syncOut out  synchronised level (last stage, registered)
//   edgeOut out  last stage differs from history flop
// ----------------------------------------------------------------------------
module spwtcr_tgl_sync
   import spwtcr_tx_sync_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic CLOCK,
   input  logic RESETn,
   input  logic tglIn,
   output logic syncOut,
   output logic edgeOut
);

   logic [STAGES-1:0] sync_r;
   logic              hist_r;

   // Synchroniser chain and edge-history flop.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         sync_r <= {STAGES{1'b0}};
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], tglIn};
         hist_r <= sync_r[STAGES-1];
      end
   end

   assign syncOut = sync_r[STAGES-1];
   assign edgeOut = sync_r[STAGES-1] ^ hist_r;

endmodule

// File: rtl/spwtcr_tx_sync.sv
// ----------------------------------------------------------------------------
// spwtcr_tx_sync
// Carries transmit requests from the sys clock domain into CLOCK.
// Toggle/ack handshakes for characters and time-codes, a saturating pending
// FCT counter and synchronised link-control levels.
// Ports:
//   CLOCK, RESETn             transmit clock, async active-low reset
//   TX_DATA_sys, TX_REQ_TGL_sys   held character and its request toggle
//   TIME_IN_sys, TICK_IN_TGL_sys  held time-code and its request toggle
//   FCT_REQ_TGL_sys           FCT request toggle
//   LINK_START/DISABLE/AUTOSTART_sys  link-control levels
//   TX_ACCEPT, FCT_SENT       encoder consumption strobes
//   TX_DATA, TX_VALID, TX_ACK_TGL  captured character, pending flag, ack
//   TICK_IN, TIME_IN, TICK_ACK_TGL time-code pulse, value, ack
//   FCT_PENDING, FCT_OVF      pending-FCT flag, sticky overflow
//   TX_OVERRUN                sticky: character request while one pending
//   LINK_START/DISABLE/AUTOSTART  synchronised levels
// ----------------------------------------------------------------------------
module spwtcr_tx_sync
   import spwtcr_tx_sync_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FCT_CNT_W   = DEF_FCT_CNT_W
) (
   input  logic              CLOCK,
   input  logic              RESETn,
   input  logic [CHAR_W-1:0] TX_DATA_sys,
   input  logic              TX_REQ_TGL_sys,
   input  logic [7:0]        TIME_IN_sys,
   input  logic              TICK_IN_TGL_sys,
   input  logic              FCT_REQ_TGL_sys,
   input  logic              LINK_START_sys,
   input  logic              LINK_DISABLE_sys,
   input  logic              AUTOSTART_sys,
   input  logic              TX_ACCEPT,
   input  logic              FCT_SENT,
   output logic [CHAR_W-1:0] TX_DATA,
   output logic              TX_VALID,
   output logic              TX_ACK_TGL,
   output logic              TICK_IN,
   output logic [7:0]        TIME_IN,
   output logic              TICK_ACK_TGL,
   output logic              FCT_PENDING,
   output logic              FCT_OVF,
   output logic              TX_OVERRUN,
   output logic              LINK_START,
   output logic              LINK_DISABLE,
   output logic              AUTOSTART
);

   localparam logic [FCT_CNT_W-1:0] FCT_MAX  = {FCT_CNT_W{1'b1}};
   localparam logic [FCT_CNT_W-1:0] FCT_ZERO = {FCT_CNT_W{1'b0}};
   localparam logic [FCT_CNT_W-1:0] FCT_ONE  = FCT_CNT_W'(1'b1);

   logic       dataEdge_s, tickEdge_s, fctEdge_s;
   logic [2:0] reqSyncUnused_s;
   logic [2:0] lvlEdgeUnused_s;

   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uDataSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(TX_REQ_TGL_sys),
      .syncOut(reqSyncUnused_s[0]), .edgeOut(dataEdge_s));
   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uTickSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(TICK_IN_TGL_sys),
      .syncOut(reqSyncUnused_s[1]), .edgeOut(tickEdge_s));
   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uFctSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(FCT_REQ_TGL_sys),
      .syncOut(reqSyncUnused_s[2]), .edgeOut(fctEdge_s));
   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uStartSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(LINK_START_sys),
      .syncOut(LINK_START), .edgeOut(lvlEdgeUnused_s[0]));
   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uDisableSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(LINK_DISABLE_sys),
      .syncOut(LINK_DISABLE), .edgeOut(lvlEdgeUnused_s[1]));
   spwtcr_tgl_sync #(.STAGES(SYNC_STAGES)) uAutoSync (
      .CLOCK(CLOCK), .RESETn(RESETn), .tglIn(AUTOSTART_sys),
      .syncOut(AUTOSTART), .edgeOut(lvlEdgeUnused_s[2]));

   dataState_t          state_r, stateNext_s;
   logic                captureEn_s, retire_s, overrunSet_s;
   logic [CHAR_W-1:0]   txData_r;
   logic                txValid_r, txAckTgl_r, txOverrun_r;
   logic                tickPulse_r, tickAckTgl_r;
   logic [7:0]          timeIn_r;
   logic [FCT_CNT_W-1:0] fctCnt_r, fctCntNext_s;
   logic                fctOvfSet_s, fctOvf_r, fctPending_r;

   // Data FSM next-state: capture in IDLE, retire on accept or link-disable flush.
   always_comb begin
      stateNext_s  = state_r;
      captureEn_s  = 1'b0;
      retire_s     = 1'b0;
      overrunSet_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (dataEdge_s) begin
               stateNext_s = PEND;
               captureEn_s = 1'b1;
            end else begin
               stateNext_s = IDLE;
            end
         end
         PEND: begin
            // The held character is kept; the new request is only flagged.
            if (dataEdge_s) begin
               overrunSet_s = 1'b1;
            end else begin
               overrunSet_s = 1'b0;
            end
            // Flush also toggles the ack so the sys side is never left waiting.
            if (TX_ACCEPT || LINK_DISABLE) begin
               stateNext_s = IDLE;
               retire_s    = 1'b1;
            end else begin
               stateNext_s = PEND;
            end
         end
         default: begin
            stateNext_s = IDLE;
         end
      endcase
   end

   // Data FSM state and character-path registers.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_r     <= IDLE;
         txData_r    <= {CHAR_W{1'b0}};
         txValid_r   <= 1'b0;
         txAckTgl_r  <= 1'b0;
         txOverrun_r <= 1'b0;
      end else begin
         state_r   <= stateNext_s;
         txValid_r <= (stateNext_s == PEND);
         if (captureEn_s) begin
            txData_r <= TX_DATA_sys;
         end
         if (retire_s) begin
            txAckTgl_r <= ~txAckTgl_r;
         end
         if (overrunSet_s) begin
            txOverrun_r <= 1'b1;
         end
      end
   end

   // Time-code pulse, captured value and ack toggle.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         tickPulse_r  <= 1'b0;
         timeIn_r     <= 8'h00;
         tickAckTgl_r <= 1'b0;
      end else begin
         tickPulse_r <= tickEdge_s;
         if (tickEdge_s) begin
            timeIn_r     <= TIME_IN_sys;
            tickAckTgl_r <= ~tickAckTgl_r;
         end
      end
   end

   // Pending-FCT counter: saturating increment, floor-at-zero decrement,
   // simultaneous request and send cancel out.
   always_comb begin
      fctCntNext_s = fctCnt_r;
      fctOvfSet_s  = 1'b0;
      if (fctEdge_s && !FCT_SENT) begin
         if (fctCnt_r == FCT_MAX) begin
            fctOvfSet_s = 1'b1;
         end else begin
            fctCntNext_s = fctCnt_r + FCT_ONE;
         end
      end else if (!fctEdge_s && FCT_SENT) begin
         if (fctCnt_r != FCT_ZERO) begin
            fctCntNext_s = fctCnt_r - FCT_ONE;
         end else begin
            fctCntNext_s = fctCnt_r;
         end
      end else begin
         fctCntNext_s = fctCnt_r;
      end
   end

   // FCT counter, pending flag and sticky overflow registers.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         fctCnt_r      <= FCT_ZERO;
         fctPending_r  <= 1'b0;
         fctOvf_r      <= 1'b0;
      end else begin
         fctCnt_r     <= fctCntNext_s;
         fctPending_r <= (fctCntNext_s != FCT_ZERO);
         if (fctOvfSet_s) begin
            fctOvf_r <= 1'b1;
         end
      end
   end

   assign TX_DATA      = txData_r;
   assign TX_VALID     = txValid_r;
   assign TX_ACK_TGL   = txAckTgl_r;
   assign TX_OVERRUN   = txOverrun_r;
   assign TICK_IN      = tickPulse_r;
   assign TIME_IN      = timeIn_r;
   assign TICK_ACK_TGL = tickAckTgl_r;
   assign FCT_PENDING  = fctPending_r;
   assign FCT_OVF      = fctOvf_r;

endmodule
